// File: rtl/mips_pkg.sv
// Shared types and constants for the simplified MIPS core front end.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package mips_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_STALL
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } if_id_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, decode control inputs, IF/ID bundle.
// Latency: wires only.
// Backpressure: stall_i from decode; master = fetch_unit, slave = memory/decode side.
interface fetch_unit_if import mips_pkg::*; #(
  parameter int ADDR_WIDTH = XLEN,
  parameter int DATA_WIDTH = XLEN
) ();

  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  stall_i;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  if_id_valid;
  logic [ADDR_WIDTH-1:0] if_id_pc;
  logic [ADDR_WIDTH-1:0] if_id_pc_plus4;
  logic [DATA_WIDTH-1:0] if_id_instr;
  logic                  fetch_misaligned;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall_i, redirect_valid, redirect_pc,
    output if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, fetch_misaligned
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall_i, redirect_valid, redirect_pc,
    input  if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, fetch_misaligned
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter: word-aligned load on redirect, +4 on advance, else hold.
// Latency: 1 cycle (registered).
// Backpressure: holds whenever neither load nor inc is asserted; load wins.
// Ports: clk, rst_n, load/load_pc (redirect target), inc (advance), pc_q.
module pc_reg import mips_pkg::*; #(
  parameter int                    ADDR_WIDTH = XLEN,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] pc_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      // Low two bits are dropped; misalignment is flagged by the caller.
      pc_q <= {load_pc[ADDR_WIDTH-1:2], 2'b00};
    end else if (inc) begin
      pc_q <= pc_q + ADDR_WIDTH'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, hides the 1-cycle memory read, registers IF/ID.
// Latency: reset release to first valid bundle 2 edges; redirect costs 2 bubbles.
// Backpressure: stall_i holds IF/ID, PC and inflight; memory re-reads the inflight word.
// Ports: clk, rst_n, bus (fetch_unit_if.master: imem_addr/imem_rdata, stall_i,
//        redirect_valid/redirect_pc, if_id_* bundle, fetch_misaligned).
// Build option FETCH_PERF_EN adds saturating perf_fetched/perf_stall_cycles/perf_redirects.
module fetch_unit import mips_pkg::*; #(
  parameter int                    ADDR_WIDTH = XLEN,
  parameter int                    DATA_WIDTH = XLEN,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects
`endif
);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  inflight_valid_q;
  logic [ADDR_WIDTH-1:0] inflight_pc_q;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  advance;   // issue pc_q and step the PC
  logic                  capture;   // move inflight word into IF/ID

  logic                  if_id_valid_q;
  logic [ADDR_WIDTH-1:0] if_id_pc_q;
  logic [ADDR_WIDTH-1:0] if_id_pc_plus4_q;
  logic [DATA_WIDTH-1:0] if_id_instr_q;
  logic                  misaligned_q;

  pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (bus.redirect_valid),
    .load_pc (bus.redirect_pc),
    .inc     (advance),
    .pc_q    (pc_q)
  );

  always_comb begin
    state_d    = state_q;
    advance    = 1'b0;
    capture    = 1'b0;
    fetch_addr = pc_q;
    case (state_q)
      // Nothing is inflight yet, so there is nothing to hold: always issue.
      S_BOOT: begin
        advance = 1'b1;
        state_d = S_RUN;
      end
      S_RUN, S_STALL: begin
        if (bus.stall_i) begin
          // Re-read the inflight word so it is still on imem_rdata at release.
          fetch_addr = inflight_pc_q;
          state_d    = S_STALL;
        end else begin
          advance = 1'b1;
          capture = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
    // Redirect overrides both stall and normal advance.
    if (bus.redirect_valid) begin
      advance = 1'b0;
      capture = 1'b0;
      state_d = S_RUN;
    end
  end

  assign bus.imem_addr = {2'b00, fetch_addr[ADDR_WIDTH-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_BOOT;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      if_id_valid_q    <= 1'b0;
      if_id_pc_q       <= '0;
      if_id_pc_plus4_q <= '0;
      if_id_instr_q    <= '0;
      misaligned_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.redirect_valid) begin
        // Squash the wrong-path bundle and the wrong-path request.
        if_id_valid_q    <= 1'b0;
        inflight_valid_q <= 1'b0;
        if (bus.redirect_pc[1:0] != 2'b00) misaligned_q <= 1'b1;
      end else if (advance) begin
        inflight_valid_q <= 1'b1;
        inflight_pc_q    <= pc_q;
        if (capture) begin
          if_id_valid_q    <= inflight_valid_q;
          if_id_pc_q       <= inflight_pc_q;
          if_id_pc_plus4_q <= inflight_pc_q + ADDR_WIDTH'(INSTR_BYTES);
          if_id_instr_q    <= bus.imem_rdata;
        end
      end
    end
  end

  assign bus.if_id_valid      = if_id_valid_q;
  assign bus.if_id_pc         = if_id_pc_q;
  assign bus.if_id_pc_plus4   = if_id_pc_plus4_q;
  assign bus.if_id_instr      = if_id_instr_q;
  assign bus.fetch_misaligned = misaligned_q;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (capture && inflight_valid_q) perf_fetched <= sat_inc(perf_fetched);
      if (bus.stall_i)                 perf_stall_cycles <= sat_inc(perf_stall_cycles);
      if (bus.redirect_valid)          perf_redirects <= sat_inc(perf_redirects);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed boundary sequences plus a randomized run.
// The expected in-order instruction stream is queued by the stimulus side; a
// negedge monitor pops and compares every bundle decode accepts.
module tb_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall_cycles, perf_redirects;
`endif

  fetch_unit #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects)
`endif
  );

  // 4096-word memory with one-cycle registered read; upper index bits ignored.
  logic [31:0] mem [4096];
  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr[11:0]];

  // Reference model: program-order stream of the bundles decode should accept.
  if_id_t      exp_q[$];
  if_id_t      mon_e;
  logic [31:0] nxt;
  logic        exp_mis;
  int          n_chk = 0;
  int          n_fail = 0;
  int          consumed = 0;
  int          n_stall = 0;
  int          n_redir = 0;
  int          c0;
  logic [31:0] rpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{valid: 1'b1, pc: nxt, pc_plus4: nxt + 32'd4, instr: mem[nxt[13:2]]});
      nxt = nxt + 32'd4;
    end
  endtask

  // Drive inputs for the next edge, update the model, then advance past the edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
    bus.stall_i        = st;
    bus.redirect_valid = rd;
    bus.redirect_pc    = tgt;
    if (rd) begin
      exp_q.delete();
      nxt = {tgt[31:2], 2'b00};
      if (tgt[1:0] != 2'b00) exp_mis = 1'b1;
      n_redir++;
    end
    if (st) n_stall++;
    refill();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bundle(input string name, input logic [31:0] pc);
    chk({name, "_valid"}, 32'(bus.if_id_valid), 32'd1);
    chk({name, "_pc"}, bus.if_id_pc, pc);
    chk({name, "_pc4"}, bus.if_id_pc_plus4, pc + 32'd4);
    chk({name, "_instr"}, bus.if_id_instr, mem[pc[13:2]]);
  endtask

  // Monitor: decode accepts a bundle at an edge where it is valid, not stalled
  // and not squashed by a redirect.
  always @(negedge clk) begin
    if (rst_n && bus.if_id_valid && !bus.stall_i && !bus.redirect_valid) begin
      consumed++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_empty: got pc %h expected no bundle", bus.if_id_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_pc", bus.if_id_pc, mon_e.pc);
        chk("sb_pc4", bus.if_id_pc_plus4, mon_e.pc_plus4);
        chk("sb_instr", bus.if_id_instr, mon_e.instr);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom();
    mem[0] = 32'h8C01_0000;
    mem[1] = 32'h0022_1820;
    mem[2] = 32'hAC03_0004;
    rst_n              = 1'b0;
    bus.stall_i        = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    nxt                = RST_PC;
    exp_mis            = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.if_id_valid), 32'd0);
    chk("rst_pc", bus.if_id_pc, 32'd0);
    chk("rst_pc4", bus.if_id_pc_plus4, 32'd0);
    chk("rst_instr", bus.if_id_instr, 32'd0);
    chk("rst_mis", 32'(bus.fetch_misaligned), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, RST_PC >> 2);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
`endif

    // Reset release: issue on edge 1, first bundle on edge 2.
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'd0);
    chk("boot_valid", 32'(bus.if_id_valid), 32'd0);
    chk("boot_imem_addr", bus.imem_addr, 32'd1);
    step(1'b0, 1'b0, 32'd0);
    chk_bundle("first", 32'h0);
    step(1'b0, 1'b0, 32'd0);
    chk_bundle("second", 32'h4);

    // Stall three edges holding PC 4; memory re-reads the inflight word (PC 8).
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'd0);
      chk_bundle("stall_hold", 32'h4);
      chk("stall_imem_addr", bus.imem_addr, 32'd2);
    end
    step(1'b0, 1'b0, 32'd0);
    chk_bundle("stall_release", 32'h8);

    // Redirect: two bubbles then the target.
    step(1'b0, 1'b1, 32'h40);
    chk("redir_bubble1", 32'(bus.if_id_valid), 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk("redir_bubble2", 32'(bus.if_id_valid), 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk_bundle("redir_target", 32'h40);

    // Redirect together with stall: redirect wins.
    step(1'b1, 1'b1, 32'h80);
    chk("redst_bubble1", 32'(bus.if_id_valid), 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk("redst_bubble2", 32'(bus.if_id_valid), 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk_bundle("redst_target", 32'h80);

    // Misaligned target: sticky flag, fetch from the aligned word.
    chk("mis_before", 32'(bus.fetch_misaligned), 32'd0);
    step(1'b0, 1'b1, 32'h42);
    chk("mis_set", 32'(bus.fetch_misaligned), 32'd1);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk_bundle("mis_target", 32'h40);
    chk("mis_sticky", 32'(bus.fetch_misaligned), 32'd1);

    // PC wrap across the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk_bundle("wrap_a", 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'd0);
    chk("wrap_pc4", bus.if_id_pc_plus4, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk_bundle("wrap_zero", 32'h0);

    // Full throughput with no stall or redirect.
    c0 = consumed;
    repeat (10) step(1'b0, 1'b0, 32'd0);
    chk("throughput", 32'(consumed - c0), 32'd10);

    // Randomized run against the scoreboard.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 7))
        0:       rpc = $urandom();
        1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
        default: rpc = 32'($urandom_range(0, 4095)) << 2;
      endcase
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, rpc);
    end
    step(1'b0, 1'b0, 32'd0);
    chk("rand_mis", 32'(bus.fetch_misaligned), 32'(exp_mis));
    chk("rand_progress", 32'(consumed > 600), 32'd1);
`ifdef FETCH_PERF_EN
    chk("perf_stall", perf_stall_cycles, 32'(n_stall));
    chk("perf_redir", perf_redirects, 32'(n_redir));
`endif

    // Reset pulsed in the middle of a stall: immediate clear, clean restart.
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.if_id_valid), 32'd0);
    chk("mid_rst_pc", bus.if_id_pc, 32'd0);
    chk("mid_rst_pc4", bus.if_id_pc_plus4, 32'd0);
    chk("mid_rst_instr", bus.if_id_instr, 32'd0);
    chk("mid_rst_mis", 32'(bus.fetch_misaligned), 32'd0);
    chk("mid_rst_imem_addr", bus.imem_addr, RST_PC >> 2);
`ifdef FETCH_PERF_EN
    chk("mid_rst_perf_fetched", perf_fetched, 32'd0);
    chk("mid_rst_perf_stall", perf_stall_cycles, 32'd0);
    chk("mid_rst_perf_redir", perf_redirects, 32'd0);
`endif
    exp_q.delete();
    nxt     = RST_PC;
    exp_mis = 1'b0;
    n_stall = 0;
    n_redir = 0;
    bus.stall_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'd0);
    chk("restart_bubble", 32'(bus.if_id_valid), 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk_bundle("restart_first", RST_PC);
    step(1'b0, 1'b0, 32'd0);
    chk_bundle("restart_second", RST_PC + 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
